// File: rtl/fx_pt_sub_rnd_pipe.sv
// fx_pt_sub_rnd_pipe: two-stage pipelined fixed-point subtractor, diff = a - b.
// a (Q AIW.AFW) and b (Q BIW.BFW) are unsigned; diff is signed Q DIW.DFW after
// requantisation with a parameter-selected rounding mode (SN: 0 floor,
// 1 round-half-up, 2 round-half-to-even, others behave as 0).
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  operand handshake; a, b operands
//   out_valid, out_ready result handshake; diff result
//   out_cnt             number of results consumed, wraps at 16 bits
module fx_pt_sub_rnd_pipe #(
  parameter int unsigned SN  = 1,
  parameter int unsigned AIW = 2,
  parameter int unsigned AFW = 3,
  parameter int unsigned BIW = 3,
  parameter int unsigned BFW = 4,
  parameter int unsigned DFW = 2,
  // Derived widths, not meant to be overridden
  parameter int unsigned DIW = ((AIW > BIW) ? AIW : BIW) + 2,
  parameter int unsigned E   = (AFW > BFW) ? AFW : BFW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AIW+AFW-1:0]     a,
  input  logic [BIW+BFW-1:0]     b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIW+DFW-1:0]     diff,
  output logic [15:0]            out_cnt
);

  localparam int unsigned R  = (DFW < E) ? E - DFW : 0;
  localparam int unsigned RW = DIW + E;
  localparam int unsigned DW = DIW + DFW;

  logic                 s1_valid_q;
  logic signed [RW-1:0] raw_q;
  logic [RW-1:0]        a_ext, b_ext, raw_d;
  logic                 out_valid_q;
  logic [DW-1:0]        diff_q, diff_d;
  logic [15:0]          out_cnt_q;

  logic in_fire, out_fire, s2_advance, s1_advance;

  // S2 can take a new value when empty or when its current value leaves this cycle.
  assign s2_advance = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_advance;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;

  // Align both operands to E fractional bits in a DIW-integer-bit frame.
  always_comb begin
    a_ext = RW'(a) << (E - AFW);
    b_ext = RW'(b) << (E - BFW);
    raw_d = a_ext - b_ext;
  end

  if (DFW >= E) begin : g_exact
    logic signed [DW-1:0] raw_ext;
    assign raw_ext = DW'(raw_q);
    assign diff_d  = raw_ext <<< (DFW - E);
  end else begin : g_round
    localparam logic [RW-1:0] Half = RW'(1) << (R - 1);
    logic [RW-1:0] rnd_sum;
    logic [DW-1:0] q_floor, q_up;
    logic          tie;
    always_comb begin
      rnd_sum = raw_q + Half;
      // Dropping the R LSBs of a two's-complement value is an arithmetic floor.
      q_floor = raw_q[RW-1:R];
      q_up    = rnd_sum[RW-1:R];
      tie     = (raw_q[R-1:0] == Half[R-1:0]);
      case (SN)
        1:       diff_d = q_up;
        2:       diff_d = (tie && !q_floor[0]) ? q_floor : q_up;
        default: diff_d = q_floor;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      raw_q      <= '0;
    end else begin
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        raw_q      <= raw_d;
      end else if (s1_advance) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
    end else if (s2_advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_advance) begin
        diff_q <= diff_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt_q <= '0;
    end else if (out_fire) begin
      out_cnt_q <= out_cnt_q + 16'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_fx_pt_sub_rnd_pipe.sv
// tb_fx_pt_sub_rnd_pipe: drives five instances (SN 0,1,2,3 at DFW=2 and SN 1 at
// DFW=5) from shared operands/handshake and compares against an arithmetic model.
module tb_fx_pt_sub_rnd_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  a = '0;
  logic [6:0]  b = '0;

  logic [4:0]  ir, ov;
  logic [6:0]  dif0, dif1, dif2, dif3;
  logic [9:0]  dif5;
  logic [15:0] cnt0, cnt1, cnt2, cnt3, cnt5;

  always #5 clk = ~clk;

  fx_pt_sub_rnd_pipe #(.SN(0)) u_sn0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(out_ready), .diff(dif0), .out_cnt(cnt0));
  fx_pt_sub_rnd_pipe #(.SN(1)) u_sn1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(out_ready), .diff(dif1), .out_cnt(cnt1));
  fx_pt_sub_rnd_pipe #(.SN(2)) u_sn2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(out_ready), .diff(dif2), .out_cnt(cnt2));
  fx_pt_sub_rnd_pipe #(.SN(3)) u_sn3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .a(a), .b(b),
    .out_valid(ov[3]), .out_ready(out_ready), .diff(dif3), .out_cnt(cnt3));
  fx_pt_sub_rnd_pipe #(.SN(1), .DFW(5)) u_dfw5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[4]), .a(a), .b(b),
    .out_valid(ov[4]), .out_ready(out_ready), .diff(dif5), .out_cnt(cnt5));

  typedef struct {
    int av;
    int bv;
    int acc;
  } item_t;

  item_t pq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    cnt_exp = 0;
  bit    last_in_fire;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact difference in units of 2^-4: a has 3 fraction bits, b has 4.
  function automatic int exact_val(input int av, input int bv);
    return av * 2 - bv;
  endfunction

  // Requantise v (units 2^-4) by dividing by 2^r with the given rounding mode.
  function automatic int requant(input int v, input int r, input int mode);
    int d, q, rem;
    d = 1 << r;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q = q - 1;
    rem = v - q * d;
    case (mode)
      1: if (rem * 2 >= d) q = q + 1;
      2: begin
        if (rem * 2 > d) q = q + 1;
        else if ((rem * 2 == d) && (q % 2 != 0)) q = q + 1;
      end
      default: ;
    endcase
    return q;
  endfunction

  task automatic cycle(input bit iv, input int av, input int bv, input bit orv);
    bit exp_ov, exp_ir;
    int v, e0, e1, e2, e5;
    @(negedge clk);
    in_valid  = iv;
    a         = av[4:0];
    b         = bv[6:0];
    out_ready = orv;
    #1;
    exp_ov = (pq.size() > 0) && (cyc >= pq[0].acc + 2);
    exp_ir = !((pq.size() == 2) && !orv);
    check("in_ready", 80'(ir), exp_ir ? 80'h1f : 80'h0);
    check("out_valid", 80'(ov), exp_ov ? 80'h1f : 80'h0);
    check("out_cnt", {cnt0, cnt1, cnt2, cnt3, cnt5},
          {5{cnt_exp[15:0]}});
    if (exp_ov && orv) begin
      v  = exact_val(pq[0].av, pq[0].bv);
      e0 = requant(v, 2, 0);
      e1 = requant(v, 2, 1);
      e2 = requant(v, 2, 2);
      e5 = v * 2;
      check("diff_sn0", 80'(dif0), 80'(e0[6:0]));
      check("diff_sn1", 80'(dif1), 80'(e1[6:0]));
      check("diff_sn2", 80'(dif2), 80'(e2[6:0]));
      check("diff_sn3", 80'(dif3), 80'(e0[6:0]));
      check("diff_dfw5", 80'(dif5), 80'(e5[9:0]));
      void'(pq.pop_front());
      cnt_exp = (cnt_exp + 1) % 65536;
    end
    last_in_fire = iv && exp_ir;
    if (last_in_fire) pq.push_back('{av: av, bv: bv, acc: cyc});
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 80'(ov), 80'h0);
    check("rst_out_cnt", {cnt0, cnt1, cnt2, cnt3, cnt5}, 80'h0);
    check("rst_in_ready", 80'(ir), 80'h1f);
    pq.delete();
    cnt_exp = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int accepted, k;
    #1;
    check("init_out_valid", 80'(ov), 80'h0);
    check("init_in_ready", 80'(ir), 80'h1f);
    check("init_diff", {dif0, dif1, dif2, dif3, dif5}, 80'h0);
    check("init_out_cnt", {cnt0, cnt1, cnt2, cnt3, cnt5}, 80'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed values: half-way positive, negative tie, both extremes, DFW>=E case.
    cycle(1'b1, 12, 18, 1'b1);
    cycle(1'b1, 0, 2, 1'b1);
    cycle(1'b1, 31, 0, 1'b1);
    cycle(1'b1, 0, 127, 1'b1);
    cycle(1'b1, 1, 1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b1);

    // Backpressure: 10 pairs, out_ready pattern 1,0,0,1.
    do_reset();
    accepted = 0;
    k = 0;
    while ((accepted < 10 || pq.size() > 0) && k < 200) begin
      cycle(accepted < 10, (accepted * 7 + 3) % 32, (accepted * 29 + 5) % 128,
            (k % 4 == 0) || (k % 4 == 3));
      if (last_in_fire) accepted++;
      k++;
    end
    check("bp_done", 80'(k < 200), 80'h1);
    @(negedge clk);
    check("bp_out_cnt", 80'(cnt1), 80'd10);

    // Reset with both stages full, then a fresh pair must emerge two cycles later.
    cycle(1'b1, 5, 9, 1'b0);
    cycle(1'b1, 6, 10, 1'b0);
    cycle(1'b1, 7, 11, 1'b0);
    do_reset();
    cycle(1'b1, 20, 33, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);

    // Random regression with random valid/ready.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 4) != 0, int'($urandom % 32), int'($urandom % 128),
            ($urandom % 4) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1);
    check("drained", 80'(pq.size()), 80'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
